// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and frame-length arithmetic.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned START_BITS = 1;
    localparam int unsigned MIN_DATA   = 5;
    localparam int unsigned MIN_STOP   = 1;
    localparam int unsigned LEN_W      = 8;

    // Unclamped frame length: start + data + optional parity + one or two stop bits.
    function automatic logic [LEN_W-1:0] calc_frame_len(
        input logic [1:0] data_bits,
        input logic       parity_en,
        input logic       stop2
    );
        return LEN_W'(START_BITS) + LEN_W'(MIN_DATA) + LEN_W'(data_bits)
             + LEN_W'(parity_en) + LEN_W'(MIN_STOP) + LEN_W'(stop2);
    endfunction

endpackage

// File: rtl/tx_frame_len.sv
// Combinational frame-length calculator with clamp to MAX_FRAME; shared by TX and RX counters.
module tx_frame_len
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_FRAME = 12
) (
    input  logic [1:0]       data_bits_i,
    input  logic             parity_en_i,
    input  logic             stop2_i,
    output logic [CNT_W-1:0] frame_len_o
);

    logic [LEN_W-1:0] raw_len;
    logic [LEN_W-1:0] clamped_len;

    assign raw_len     = calc_frame_len(data_bits_i, parity_en_i, stop2_i);
    assign clamped_len = (raw_len > LEN_W'(MAX_FRAME)) ? LEN_W'(MAX_FRAME) : raw_len;
    assign frame_len_o = CNT_W'(clamped_len);

endmodule

// File: rtl/tx_frame_bit_counter.sv
// Counts baud ticks across one TX frame whose length is latched at frame start;
// reports bit index, shift strobe, done level/pulse and abort pulse to the TX controller.
module tx_frame_bit_counter
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_FRAME = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btu,
    input  logic             doit,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             stop2,
    output logic [CNT_W-1:0] bit_idx,
    output logic [CNT_W-1:0] frame_len,
    output logic             shift,
    output logic             done,
    output logic             done_pulse,
    output logic             abort
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] frame_len_q, frame_len_d;
    logic             done_q, done_d;
    logic             done_pulse_q, done_pulse_d;
    logic             abort_q, abort_d;
    logic [CNT_W-1:0] cfg_len;
    logic             last_bit;

    tx_frame_len #(
        .CNT_W     (CNT_W),
        .MAX_FRAME (MAX_FRAME)
    ) u_frame_len (
        .data_bits_i (data_bits),
        .parity_en_i (parity_en),
        .stop2_i     (stop2),
        .frame_len_o (cfg_len)
    );

    assign last_bit = (bit_idx_q == (frame_len_q - CNT_W'(1)));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            frame_len_q  <= '0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            frame_len_q  <= frame_len_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
            abort_q      <= abort_d;
        end
    end

    // Next state and next count; a dropped doit takes priority over a same-cycle tick
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        frame_len_d = frame_len_q;
        unique case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (doit) begin
                    state_d     = COUNT;
                    frame_len_d = cfg_len;
                end
            end
            COUNT: begin
                if (!doit) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                end else if (btu) begin
                    if (last_bit) begin
                        state_d   = DONE;
                        bit_idx_d = frame_len_q;
                    end else begin
                        bit_idx_d = bit_idx_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (!doit) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // Output decode: shift is same-cycle, the rest feed output registers
    always_comb begin
        shift        = btu & doit & (state_q == COUNT) & ~last_bit;
        done_d       = (state_d == DONE);
        done_pulse_d = (state_q == COUNT) & (state_d == DONE);
        abort_d      = (state_q == COUNT) & ~doit;
    end

    assign bit_idx    = bit_idx_q;
    assign frame_len  = frame_len_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign abort      = abort_q;

endmodule
